// File: rtl/encoder_4to2_hs_pkg.sv
// Shared types, constants and helpers for the registered 4-to-2 encoder.
package enc_pkg;

    localparam int unsigned CODE_W = 2;
    localparam int unsigned NREQ   = 4;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // True when at least two request lines are asserted (active-high vector).
    function automatic logic popcount_ge2(input logic [NREQ-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                cnt = cnt + 1;
            end
        end
        return (cnt >= 2);
    endfunction

endpackage

// File: rtl/encoder_4to2_hs_prio_sel_4.sv
// Combinational 4-way request selector: fixed priority (high or low index wins)
// or round-robin starting one past i_ptr. Also reports any/multi request.
module prio_sel_4
    import enc_pkg::*;
(
    input  logic [NREQ-1:0]   i_req,
    input  logic [CODE_W-1:0] i_ptr,
    input  logic              i_rr,
    input  logic              i_prio_high,
    output logic [CODE_W-1:0] o_idx,
    output logic              o_any,
    output logic              o_multi
);

    logic              w_found;
    logic [CODE_W-1:0] w_cand;

    // Select the winning request index according to the active mode.
    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        if (i_rr) begin
            // Visit ptr+1, ptr+2, ptr+3, ptr (mod 4); the first asserted line wins.
            for (int unsigned k = 1; k <= NREQ; k++) begin
                w_cand = i_ptr + k[CODE_W-1:0];
                if (!w_found && i_req[w_cand]) begin
                    o_idx   = w_cand;
                    w_found = 1'b1;
                end
            end
        end else if (i_prio_high) begin
            // Ascending scan: the last hit is the highest index.
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (i_req[i]) begin
                    o_idx = i[CODE_W-1:0];
                end
            end
        end else begin
            // Descending scan: the last hit is the lowest index.
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (i_req[NREQ-1-i]) begin
                    o_idx = CODE_W'(NREQ - 1 - i);
                end
            end
        end
    end

    // Request summary flags.
    always_comb begin
        o_any   = |i_req;
        o_multi = popcount_ge2(i_req);
    end

endmodule

// File: rtl/encoder_4to2_hs.sv
// Registered 4-to-2 encoder with valid/ready output handshake and a
// saturating multi-hot error counter. Inputs are active-low one-cold lines.
// Optional build macro ENC_RR_EN: round-robin selection instead of fixed priority.
module encoder_4to2_hs
    import enc_pkg::*;
#(
    parameter int unsigned PRIORITY_HIGH = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  d_n,
    input  logic             ready,
    output logic             a,
    output logic             b,
    output logic             valid,
    output logic             multi,
    output logic [CNT_W-1:0] err_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_a;
    logic              r_b;
    logic              r_valid;
    logic              r_multi;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [NREQ-1:0]   w_req;
    logic [CODE_W-1:0] w_idx;
    logic [CODE_W-1:0] w_ptr;
    logic              w_any;
    logic              w_multi;
    logic              w_cap;
    logic              w_rr;

    assign w_req = ~d_n;

`ifdef ENC_RR_EN
    logic [CODE_W-1:0] r_ptr;

    // Round-robin pointer follows the last granted index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '1;
        end else if (w_cap) begin
            r_ptr <= w_idx;
        end
    end

    assign w_ptr = r_ptr;
    assign w_rr  = 1'b1;
`else
    assign w_ptr = '0;
    assign w_rr  = 1'b0;
`endif

    prio_sel_4 u_sel (
        .i_req       (w_req),
        .i_ptr       (w_ptr),
        .i_rr        (w_rr),
        .i_prio_high (PRIORITY_HIGH != 0),
        .o_idx       (w_idx),
        .o_any       (w_any),
        .o_multi     (w_multi)
    );

    // Next-state and capture decision; HOLD ignores inputs until ready.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_any) begin
                    w_cap       = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (en && w_any) begin
                        w_cap = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers; code/multi persist after the handshake ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == HOLD);
            if (w_cap) begin
                {r_a, r_b} <= w_idx;
                r_multi    <= w_multi;
            end
        end
    end

    // Saturating count of multi-hot captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_cap && w_multi && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign valid   = r_valid;
    assign multi   = r_multi;
    assign err_cnt = r_err_cnt;

endmodule
